// File: rtl/mips_data_responder_pkg.sv
// Shared definitions for the MIPS data-side responder: MMIO map, STATUS bit
// positions and the address-region decode type.
package mips_mem_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_CYCLE  = 4'h4;
  localparam logic [3:0] OFF_CMP    = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int ST_PEND = 0;
  localparam int ST_EN   = 1;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/mips_data_responder_if.sv
// Core-to-responder data bus: store strobe, byte address, store and load data.
interface mips_data_responder_if;

  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);

endinterface

// File: rtl/mips_data_responder_timer.sv
// Free-running cycle counter, compare register and STATUS (pending/enable)
// with match detection; exposes register read data and the interrupt.
module mips_timer
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pend_q, pend_d;
  logic        en_q, en_d;
  logic        match;
  logic        st_wr;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    st_wr   = wr_en && (off == OFF_STATUS);
    // Match uses the pre-write enable/compare, and a match beats a clear.
    match   = en_q && (cycle_q == cmp_q);
    if (wr_en && (off == OFF_CMP)) cmp_d = wdata;
    if (st_wr) en_d = wdata[ST_EN];
    if (match) pend_d = 1'b1;
    else if (st_wr && wdata[ST_PEND]) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      cmp_q   <= '0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CYCLE:  rdata = cycle_q;
      OFF_CMP:    rdata = cmp_q;
      OFF_STATUS: begin
        rdata[ST_PEND] = pend_q;
        rdata[ST_EN]   = en_q;
      end
      default:    rdata = '0;
    endcase
  end

  assign irq = pend_q & en_q;

endmodule

// File: rtl/mips_data_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus an LED
// register and timer block; loads are combinational, stores commit on the edge.
module mips_data_responder
  import mips_mem_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = mips_mem_pkg::MMIO_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_data_responder_if.slave  bus,
  output logic [7:0]            leds,
  output logic                  timer_irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0] ram_q [RAM_WORDS];
  logic [7:0]  led_q, led_d;
  region_e     region;
  logic [3:0]  off;
  logic [AW-1:0] idx;
  logic        ram_we;
  logic        mmio_we;
  logic [31:0] tmr_rdata;

  always_comb begin
    region = REG_NONE;
    if (bus.addr < RAM_BYTES) region = REG_RAM;
    else if (bus.addr[31:4] == MMIO_BASE[31:4]) region = REG_MMIO;
    off     = {bus.addr[3:2], 2'b00};
    idx     = bus.addr[AW+1:2];
    // RAM has no reset, so a store overlapping reset must be blocked here.
    ram_we  = bus.memwrite && (region == REG_RAM) && !reset;
    mmio_we = bus.memwrite && (region == REG_MMIO);
    led_d   = led_q;
    if (mmio_we && (off == OFF_LED)) led_d = bus.writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx] <= bus.writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_q <= '0;
    else       led_q <= led_d;
  end

  mips_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr_en (mmio_we),
    .off   (off),
    .wdata (bus.writedata),
    .rdata (tmr_rdata),
    .irq   (timer_irq)
  );

  always_comb begin
    bus.readdata = '0;
    case (region)
      REG_RAM:  bus.readdata = ram_q[idx];
      REG_MMIO: bus.readdata = (off == OFF_LED) ? {24'b0, led_q} : tmr_rdata;
      default:  bus.readdata = '0;
    endcase
  end

  assign leds = led_q;

endmodule

// File: tb/tb_mips_data_responder.sv
// Bench for mips_data_responder: directed scenarios plus a randomized run,
// all checked against a behavioural memory-map model.
module tb_mips_data_responder;

  localparam logic [31:0] BASE      = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BYTES = 32'd256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  leds;
  logic        timer_irq;
  int          n_cmp = 0;
  int          n_fail = 0;

  mips_data_responder_if bus();

  mips_data_responder #(.RAM_WORDS(64), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .leds      (leds),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model of the memory map
  logic [31:0] m_ram [64];
  bit          m_valid [64];
  logic [7:0]  m_led;
  logic [31:0] m_cyc, m_cmp;
  bit          m_pend, m_en;

  function automatic void model_reset();
    m_led = 8'h0; m_cyc = 0; m_cmp = 0; m_pend = 0; m_en = 0;
  endfunction

  function automatic void model_edge(bit we, logic [31:0] a, logic [31:0] d);
    bit hit = m_en && (m_cyc == m_cmp);
    if (we) begin
      if (a < RAM_BYTES) begin
        m_ram[a[7:2]] = d;
        m_valid[a[7:2]] = 1'b1;
      end else if (a >= BASE && (a - BASE) < 32'd16) begin
        case ((a - BASE) >> 2)
          0: m_led = d[7:0];
          2: m_cmp = d;
          3: begin
            m_en = d[1];
            if (d[0]) m_pend = 1'b0;
          end
          default: ;
        endcase
      end
    end
    if (hit) m_pend = 1'b1;
    m_cyc = m_cyc + 1;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (a < RAM_BYTES) return m_ram[a[7:2]];
    if (a >= BASE && (a - BASE) < 32'd16) begin
      case ((a - BASE) >> 2)
        0: return {24'b0, m_led};
        1: return m_cyc;
        2: return m_cmp;
        default: return {30'b0, m_en, m_pend};
      endcase
    end
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!reset) model_edge(bus.memwrite, bus.addr, bus.writedata);
  end

  task automatic tick(input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = we; bus.addr = a; bus.writedata = d;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic look(input logic [31:0] a);
    bus.memwrite = 1'b0; bus.addr = a;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(1'b0, 32'h0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %h want 00", leds); end
    n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    tick(1'b1, BASE, 32'hFF);
    tick(1'b0, 32'h0, 32'h0);
    look(BASE + 4);
    n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_cycle: got %h want 0", bus.readdata); end
    look(BASE);
    n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_store_lost: got %h want 0", bus.readdata); end
    look(BASE + 12);
    n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", bus.readdata); end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_ram();
    tick(1'b1, 32'h10, 32'hDEADBEEF);
    look(32'h10);
    n_cmp++; if (bus.readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd: got %h want deadbeef", bus.readdata); end
    look(32'h13);
    n_cmp++; if (bus.readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd_unaligned: got %h want deadbeef", bus.readdata); end
    tick(1'b1, 32'hFC, 32'hCAFEF00D);
    look(32'hFC);
    n_cmp++; if (bus.readdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ram_last_word: got %h want cafef00d", bus.readdata); end
  endtask

  task automatic test_oor_led();
    tick(1'b1, 32'h100, 32'h12345678);
    look(32'h100);
    n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL oor_read: got %h want 0", bus.readdata); end
    look(32'h0);
    n_cmp++; if (bus.readdata === 32'h12345678) begin n_fail++; $display("FAIL oor_alias: got %h want not 12345678", bus.readdata); end
    tick(1'b1, BASE, 32'h1A5);
    n_cmp++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_out: got %h want a5", leds); end
    look(BASE);
    n_cmp++; if (bus.readdata !== 32'hA5) begin n_fail++; $display("FAIL led_read: got %h want a5", bus.readdata); end
    tick(1'b1, BASE + 32'h10, 32'h77);
    look(BASE + 32'h10);
    n_cmp++; if (bus.readdata !== 32'h0 || leds !== 8'hA5) begin n_fail++; $display("FAIL mmio_hole: got %h/%h want 0/a5", bus.readdata, leds); end
  endtask

  task automatic test_cycle();
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b0, 32'h0, 32'h0);
    look(BASE + 4);
    n_cmp++; if (bus.readdata !== 32'd7) begin n_fail++; $display("FAIL cycle_count: got %0d want 7", bus.readdata); end
    tick(1'b1, BASE + 4, 32'h55);
    look(BASE + 4);
    n_cmp++; if (bus.readdata !== 32'd8) begin n_fail++; $display("FAIL cycle_ro: got %0d want 8", bus.readdata); end
  endtask

  task automatic test_timer();
    do_reset();
    tick(1'b1, BASE + 8, 32'd20);
    tick(1'b1, BASE + 12, 32'h2);
    for (int k = 3; k <= 25; k++) begin
      tick(1'b0, 32'h0, 32'h0);
      n_cmp++; if (timer_irq !== (k >= 21)) begin n_fail++; $display("FAIL timer_match_c%0d: got %b want %b", k, timer_irq, k >= 21); end
    end
    tick(1'b1, BASE + 12, 32'h3);
    n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_clear: got %b want 0", timer_irq); end
    tick(1'b1, BASE + 8, 32'd30);
    for (int k = 0; k < 3; k++) tick(1'b0, 32'h0, 32'h0);
    tick(1'b1, BASE + 12, 32'h3);
    n_cmp++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL timer_set_wins: got %b want 1", timer_irq); end
    look(BASE + 12);
    n_cmp++; if (bus.readdata !== 32'h3) begin n_fail++; $display("FAIL timer_status: got %h want 3", bus.readdata); end
  endtask

  task automatic test_enable_gating();
    do_reset();
    tick(1'b1, BASE + 8, 32'd10);
    for (int k = 2; k <= 15; k++) begin
      tick(1'b0, 32'h0, 32'h0);
      n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL gate_off_c%0d: got %b want 0", k, timer_irq); end
    end
    look(BASE + 12);
    n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL gate_pending: got %h want 0", bus.readdata); end
    tick(1'b1, BASE + 12, 32'h2);
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 32'h0, 32'h0);
      n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL gate_late_en_%0d: got %b want 0", k, timer_irq); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, BASE, 32'hFF);
    tick(1'b1, BASE + 8, 32'd5);
    tick(1'b1, BASE + 12, 32'h2);
    for (int k = 0; k < 3; k++) tick(1'b0, 32'h0, 32'h0);
    n_cmp++; if (timer_irq !== 1'b1 || leds !== 8'hFF) begin n_fail++; $display("FAIL arst_setup: got irq=%b leds=%h want 1/ff", timer_irq, leds); end
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (leds !== 8'h00) begin n_fail++; $display("FAIL arst_leds: got %h want 00", leds); end
    n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %b want 0", timer_irq); end
    tick(1'b1, 32'h10, 32'h0);
    reset = 1'b0;
    look(BASE + 4);
    n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL arst_cycle: got %h want 0", bus.readdata); end
    look(32'h10);
    n_cmp++; if (bus.readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL arst_ram_kept: got %h want deadbeef", bus.readdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit we;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 255));
        1, 2: a = BASE + 32'($urandom_range(0, 15));
        default: a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(256, 4096)) : $urandom;
      endcase
      we = ($urandom_range(0, 2) != 0);
      d = $urandom;
      if (a >= BASE && (a - BASE) < 32'd16 && ((a - BASE) >> 2) == 2) d = m_cyc + 32'($urandom_range(1, 6));
      look(a);
      if (!(a < RAM_BYTES && !m_valid[a[7:2]])) begin
        n_cmp++;
        if (bus.readdata !== model_read(a)) begin n_fail++; $display("FAIL rand_read_%0d @%h: got %h want %h", i, a, bus.readdata, model_read(a)); end
      end
      tick(we, a, d);
      n_cmp++;
      if (leds !== m_led || timer_irq !== (m_pend & m_en)) begin
        n_fail++; $display("FAIL rand_out_%0d: got leds=%h irq=%b want %h/%b", i, leds, timer_irq, m_led, m_pend & m_en);
      end
    end
  endtask

  initial begin
    bus.memwrite = 1'b0; bus.addr = 32'h0; bus.writedata = 32'h0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    model_reset();
    test_reset();
    test_ram();
    test_oor_led();
    test_cycle();
    test_timer();
    test_enable_gating();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_data_responder.md
Name: mips_data_responder

Overview:
- Data-side responder for the single-cycle MIPS core; answers the core's store-enable / address / write-data / read-data bus.
- Holds a word-addressed data RAM and a small memory-mapped I/O block: LED register, free-running cycle counter, and a compare timer with an interrupt flag.
- Read path is combinational, because the core consumes load data in the same cycle. All writes commit on the rising clock edge.

Parameters:
- RAM_WORDS, 64: number of 32-bit RAM words; must be a power of two.
- MMIO_BASE, 32'hFFFF0000: base address of the I/O register block.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- memwrite  input  1  store strobe from core; qualifies addr/writedata for one cycle
- addr  input  32  byte address from core ALU result; addr[1:0] ignored
- writedata  input  32  store data
- readdata  output  32  load data, combinational from addr
- leds  output  8  LED register contents
- timer_irq  output  1  pending & enable

Behaviour:
- Memory map. Anything not listed below: reads return 0, writes are ignored.
  - RAM: addr < RAM_WORDS*4. Word index is addr[log2(RAM_WORDS)+1:2].
  - MMIO_BASE+0x0 LED: R/W, bits[7:0]; upper bits read 0.
  - MMIO_BASE+0x4 CYCLE: read-only; writes ignored.
  - MMIO_BASE+0x8 CMP: R/W, 32 bits.
  - MMIO_BASE+0xC STATUS: bit0 pending (write 1 to clear), bit1 enable (R/W); other bits read 0.
- Async reset clears LED, CYCLE, CMP, pending and enable to 0. Therefore leds=0 and timer_irq=0 while reset is asserted and after it. RAM contents are not reset. MMIO readdata during reset reflects the cleared registers.
- Writes: when memwrite=1 at a rising edge, the addressed location takes writedata. The new value is visible on readdata from the next cycle. There is no partial-word store; always a full 32-bit word.
- Reads: readdata updates combinationally with addr and the current register/RAM state. Zero cycles of latency; memwrite has no effect on the read value within the same cycle.
- CYCLE: increments by 1 every clock while not in reset and wraps 0xFFFFFFFF -> 0. A read returns the pre-increment value of the current cycle.
- Timer match: if enable=1 and CYCLE == CMP at a rising edge, pending <= 1.
  - Match and a write-1-to-clear of pending at the same edge: set wins, pending stays 1.
  - Writing STATUS updates enable from writedata[1] and clears pending if writedata[0]=1. Writing 0 to bit0 leaves pending unchanged.
  - The match check uses the old enable and old CMP during a same-cycle write. A new CMP or enable affects matching from the next edge.
  - With enable=0, pending holds its value and timer_irq=0.
- timer_irq is a registered-state output (pending & enable) with no combinational path from inputs.
- Reset mid-operation: CYCLE, CMP, STATUS and LED return to 0 immediately. Any store coinciding with reset is lost.

Decomposition:
- Shared package mips_mem_pkg holds:
  - MMIO_BASE and the register offsets (OFF_LED=0x0, OFF_CYCLE=0x4, OFF_CMP=0x8, OFF_STATUS=0xC);
  - STATUS bit positions (ST_PEND=0, ST_EN=1);
  - the address-region decode type enum {REG_RAM, REG_MMIO, REG_NONE}.
- One natural sub-module, mips_timer: CYCLE, CMP and STATUS registers plus the match/pending logic. It exposes register read data and timer_irq.
- RAM and LED stay in the top level.

Test Plan:
- RAM round-trip: store 0xDEADBEEF to 0x00000010, then load 0x00000010 -> readdata=0xDEADBEEF. Load 0x00000013 -> same word.
- Out-of-range and LED masking:
  - Store 0x12345678 to 0x00000100 (RAM_WORDS=64) -> ignored; load 0x00000100 -> 0.
  - Store 0x1A5 to MMIO_BASE+0 -> leds=0xA5; load -> 0x000000A5.
- Cycle counter: release reset, read CYCLE N clocks later -> N. Write 0x55 to CYCLE -> ignored, counting continues.
- Timer match and clear:
  - Write CMP=20, then STATUS=0x2 -> timer_irq rises the cycle after CYCLE==20.
  - Write STATUS=0x3 -> pending cleared, timer_irq=0 next cycle.
  - Clear coinciding with a match -> pending stays 1.
- Enable gating: with enable=0, CYCLE passing CMP -> pending stays 0 and timer_irq=0. Enable afterward -> no interrupt until CYCLE wraps back to CMP.
- Async reset mid-run: assert reset between edges with leds=0xFF and pending=1 -> leds=0 and timer_irq=0 immediately. CYCLE reads 0 after release; RAM word 0x10 still reads its prior value.
